// File: rtl/input_conditioner.sv
// Purpose: shared game-tick divider plus per-channel button synchroniser, debounce, press/release and auto-repeat.
// Latency: raw change to sync in 2 clks; a level is accepted DEBOUNCE_TICKS ticks later; all pulses are registered and one clk wide.
// Backpressure: none; this is a free-running stream and every pulse is presented exactly once.
module input_conditioner #(
    parameter int CHANNELS       = 5,
    parameter int CLK_DIV        = 6000,
    parameter int DEBOUNCE_TICKS = 8,
    parameter int REPEAT_DELAY   = 200,
    parameter int REPEAT_RATE    = 40
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic                tick,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_p,
    output logic [CHANNELS-1:0] action
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int DB_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RC_W    = $clog2(RPT_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [RC_W-1:0]  RD_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0]  RR_LAST  = RC_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rstate_t;

    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick_q, tick_d;
    logic [CHANNELS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d, rel_q, rel_d, action_q, action_d;
    logic [CHANNELS-1:0] rep_evt;
    logic [DB_W-1:0]     dcnt_q [CHANNELS];
    logic [DB_W-1:0]     dcnt_d [CHANNELS];
    logic [RC_W-1:0]     rcnt_q [CHANNELS];
    logic [RC_W-1:0]     rcnt_d [CHANNELS];
    rstate_t             st_q   [CHANNELS];
    rstate_t             st_d   [CHANNELS];

    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d   = (div_q == DIV_LAST);
        sync1_d  = raw_in;
        sync2_d  = sync1_q;
        level_d  = level_q;
        press_d  = '0;
        rel_d    = '0;
        rep_evt  = '0;
        action_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            dcnt_d[c] = dcnt_q[c];
            rcnt_d[c] = rcnt_q[c];
            st_d[c]   = st_q[c];
            if (tick_q) begin
                if (sync2_q[c] == level_q[c]) begin
                    dcnt_d[c] = '0;
                end else if (dcnt_q[c] == DB_LAST) begin
                    level_d[c] = sync2_q[c];
                    dcnt_d[c]  = '0;
                    press_d[c] = sync2_q[c];
                    rel_d[c]   = ~sync2_q[c];
                end else begin
                    dcnt_d[c] = dcnt_q[c] + 1'b1;
                end

                case (st_q[c])
                    IDLE: begin
                        if (press_d[c] && repeat_en[c]) begin
                            st_d[c]   = DELAY;
                            rcnt_d[c] = '0;
                        end
                    end
                    DELAY: begin
                        if (rcnt_q[c] == RD_LAST) begin
                            rep_evt[c] = 1'b1;
                            st_d[c]    = REPEAT;
                            rcnt_d[c]  = '0;
                        end else begin
                            rcnt_d[c] = rcnt_q[c] + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rcnt_q[c] == RR_LAST) begin
                            rep_evt[c] = 1'b1;
                            rcnt_d[c]  = '0;
                        end else begin
                            rcnt_d[c] = rcnt_q[c] + 1'b1;
                        end
                    end
                    default: st_d[c] = IDLE;
                endcase
            end
            // A release or disabled repeat cancels the sequence, including a coincident event.
            if (rel_d[c] || !repeat_en[c]) begin
                st_d[c]    = IDLE;
                rcnt_d[c]  = '0;
                rep_evt[c] = 1'b0;
            end
            action_d[c] = press_d[c] | rep_evt[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            tick_q   <= 1'b0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            level_q  <= '0;
            press_q  <= '0;
            rel_q    <= '0;
            action_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                dcnt_q[c] <= '0;
                rcnt_q[c] <= '0;
                st_q[c]   <= IDLE;
            end
        end else begin
            div_q    <= div_d;
            tick_q   <= tick_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            action_q <= action_d;
            for (int c = 0; c < CHANNELS; c++) begin
                dcnt_q[c] <= dcnt_d[c];
                rcnt_q[c] <= rcnt_d[c];
                st_q[c]   <= st_d[c];
            end
        end
    end

    assign tick      = tick_q;
    assign level     = level_q;
    assign press     = press_q;
    assign release_p = rel_q;
    assign action    = action_q;

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised successor to the single-button tick/debounce logic in the top-level game module.
- Generates one system game tick and conditions CHANNELS raw button inputs.
- Per channel: 2-FF synchroniser, counter-based debounce, press/release pulses, optional auto-repeat (held-button menu scrolling).
- Sits between the board pins and the MainFsm, PausedMenu and Paddle logic. Replaces ad-hoc sampling with one shared, verified block.

Parameters:
- CHANNELS, 5: number of button inputs (p1 up/down, p2 up/down, enter); valid ≥1.
- CLK_DIV, 6000: clk cycles per tick; valid ≥2.
- DEBOUNCE_TICKS, 8: consecutive mismatching tick samples required to accept a new level; valid ≥1.
- REPEAT_DELAY, 200: ticks from accepted press to first auto-repeat pulse; valid ≥1.
- REPEAT_RATE, 40: ticks between subsequent auto-repeat pulses; valid ≥1.

Ports:
- clk  input  1  system clock (12 MHz HSOSC)
- reset  input  1  synchronous, active-high reset
- raw_in  input  CHANNELS  asynchronous button levels, 1 = pressed
- repeat_en  input  CHANNELS  per-channel auto-repeat enable
- tick  output  1  one-clk pulse every CLK_DIV clks
- level  output  CHANNELS  debounced button level
- press  output  CHANNELS  one-clk pulse on accepted 0→1
- release  output  CHANNELS  one-clk pulse on accepted 1→0
- action  output  CHANNELS  one-clk pulse: press OR auto-repeat event

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset. All state updates on posedge clk. Reset dominates all other inputs in the same cycle.
- Reset values:
  - div counter 0; tick 0.
  - sync FFs 0; level 0; press/release/action 0.
  - debounce counters 0; repeat FSMs IDLE; repeat counters 0.
- Tick divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - tick is registered, high for exactly one clk when div_cnt wraps.
  - First tick is in clk cycle CLK_DIV after reset deasserts, then every CLK_DIV cycles.
- Synchroniser: 2 FFs per channel. A raw change before edge k appears in sync at edge k+2.
- Debounce, per channel, evaluated only on tick cycles:
  - sync == level: counter ← 0.
  - sync != level and counter < DEBOUNCE_TICKS-1: counter +1.
  - sync != level and counter == DEBOUNCE_TICKS-1: level ← sync, counter ← 0, and on the same edge press (rising) or release (falling) ← 1 for one clk.
  - A bounce back to the old level on any tick clears the counter; no pulse is emitted.
  - Non-tick cycles hold the counter.
  - Counter width is $clog2(DEBOUNCE_TICKS+1); it never exceeds DEBOUNCE_TICKS-1.
- Auto-repeat FSM, per channel; states IDLE, DELAY, REPEAT:
  - IDLE → DELAY on accepted press with repeat_en=1; rcnt ← 0.
  - DELAY: rcnt +1 per tick. On the tick where rcnt == REPEAT_DELAY-1: repeat event, → REPEAT, rcnt ← 0.
  - REPEAT: rcnt +1 per tick. On the tick where rcnt == REPEAT_RATE-1: repeat event, rcnt ← 0.
  - Any state → IDLE, rcnt ← 0 on: accepted release, repeat_en=0 (next edge), or reset. A release pulse pre-empts a coincident repeat event (no action that cycle).
  - Press with repeat_en=0: FSM stays IDLE. Asserting repeat_en later while held does not start repeating; the next accepted press does.
- action = registered (press | repeat event); one clk wide, never two consecutive cycles.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.
- Arithmetic is unsigned; all counters are sized by $clog2 of their terminal value + 1; no wrap beyond terminal value.

Test Plan:
- Reset/tick (CLK_DIV=4): hold reset 3 clks, release → tick high in cycles 4, 8, 12 after release, low otherwise; all other outputs 0.
- Clean press (CLK_DIV=4, DEBOUNCE_TICKS=3, repeat_en=0): raw_in[0] 0→1 held → level[0] rises on the 3rd tick after sync sees 1; press[0] and action[0] high that one clk only; release/press on other channels stay 0.
- Bounce rejection: raw_in[1] high for 2 ticks, low 1 tick, high 3 ticks → exactly one press[1], coincident with the 3rd tick of the final high run; no release[1].
- Auto-repeat (DEBOUNCE_TICKS=1, REPEAT_DELAY=5, REPEAT_RATE=2, repeat_en[2]=1): hold raw_in[2] → action[2] at press tick T, then T+5, T+7, T+9 ticks; releasing it → release[2] pulse, no further action.
- repeat_en drop mid-DELAY: clear repeat_en[2] 2 ticks after press → no repeat action while still held; level[2] stays 1.
- Reset mid-operation: assert reset while channel 3 is in REPEAT with level=1 → next clk level[3]=0, FSM IDLE, no pulses; held raw_in re-debounces to a fresh press after reset releases.
